// File: rtl/charmatrix_pkg.sv
// Shared types and constants for the character-matrix serial receive path.
package charmatrix_pkg;

  localparam int DATA_BITS        = 8;
  localparam int CLKS_PER_BIT_DEF = 87;  // 10 MHz / 115200

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_t;

endpackage

// File: rtl/charmatrix_uart_rx_if.sv
// Byte hand-off from the UART receiver to the character/command decoder.
// parity_err exists only when CHARMATRIX_UART_RX_PARITY_EN is defined.
interface charmatrix_uart_rx_if;
  import charmatrix_pkg::*;

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;
`ifdef CHARMATRIX_UART_RX_PARITY_EN
  logic                 parity_err;

  modport master (output rx_data, rx_valid, frame_err, overrun, busy, parity_err,
                  input  rx_ready);
  modport slave  (input  rx_data, rx_valid, frame_err, overrun, busy, parity_err,
                  output rx_ready);
`else
  modport master (output rx_data, rx_valid, frame_err, overrun, busy,
                  input  rx_ready);
  modport slave  (input  rx_data, rx_valid, frame_err, overrun, busy,
                  output rx_ready);
`endif

endinterface

// File: rtl/charmatrix_sync2.sv
// Generic 2-FF synchronizer for asynchronous single-bit inputs; RST_VAL sets the
// value both flops take in reset so the output is quiet until the line settles.
module charmatrix_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/charmatrix_uart_rx.sv
// UART receive front end: 8N1 (or 8E1 with CHARMATRIX_UART_RX_PARITY_EN) into a
// one-entry valid/ready holding register with framing/overrun/parity pulses.
module charmatrix_uart_rx
  import charmatrix_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  charmatrix_uart_rx_if.master bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_cfg
      $error("charmatrix_uart_rx: CLKS_PER_BIT must be >= 4");
    end
  endgenerate

  logic rxs;

  charmatrix_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx),
    .q_o   (rxs)
  );

  uart_rx_state_t       state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2:0]           bit_idx_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 ferr_q;
  logic                 ovr_q;
  logic                 par_bad;
`ifdef CHARMATRIX_UART_RX_PARITY_EN
  logic                 par_q;
  logic                 perr_q;

  assign par_bad = ^{shreg_q, par_q};
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef CHARMATRIX_UART_RX_PARITY_EN
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
`ifdef CHARMATRIX_UART_RX_PARITY_EN
      perr_q <= 1'b0;
`endif
      // Drain first; a byte completing in the same cycle overrides below.
      if (valid_q && bus.rx_ready) valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!rxs) state_q <= START;
        end
        START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            state_q   <= rxs ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q     <= '0;
            shreg_q   <= {rxs, shreg_q[DATA_BITS-1:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
`ifdef CHARMATRIX_UART_RX_PARITY_EN
            if (bit_idx_q == IDX_LAST) state_q <= PARITY;
`else
            if (bit_idx_q == IDX_LAST) state_q <= STOP;
`endif
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`ifdef CHARMATRIX_UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            par_q   <= rxs;
            state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`endif
        STOP: begin
          // Leave mid stop bit so a following start edge is never missed.
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            if (!rxs) begin
              ferr_q <= 1'b1;
            end else if (par_bad) begin
`ifdef CHARMATRIX_UART_RX_PARITY_EN
              perr_q <= 1'b1;
`endif
            end else if (!valid_q || bus.rx_ready) begin
              data_q  <= shreg_q;
              valid_q <= 1'b1;
            end else begin
              ovr_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;
  assign bus.busy      = (state_q != IDLE);
`ifdef CHARMATRIX_UART_RX_PARITY_EN
  assign bus.parity_err = perr_q;
`endif

endmodule

// File: doc/charmatrix_uart_rx.md
Name: charmatrix_uart_rx

Overview:
- Serial receive front end of the character-matrix design.
- Converts the asynchronous UART line on a dedicated input into bytes.
- Hands each byte to the downstream character/command decoder through a one-entry valid/ready holding register.
- Flags framing errors and overruns so the decoder can drop corrupted characters.

Parameters:
- CLKS_PER_BIT, 87, clock cycles per bit (10 MHz / 115200); must be >= 4, elaboration error otherwise.
- HALF_BIT, CLKS_PER_BIT/2, cycles from start-edge detection to the start-bit verification sample.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx  in  1  raw UART line, idle high, asynchronous to clk
- rx_data  out  8  received byte, valid while rx_valid=1
- rx_valid  out  1  holding register full
- rx_ready  in  1  consumer accepts byte when rx_valid & rx_ready
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- overrun  out  1  one-cycle pulse: byte completed while holding register full and not being drained
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset, asserted asynchronously:
  - state=IDLE, all counters 0.
  - Synchronizer flops preset to 1 (line idle).
  - Outputs: rx_data=0x00, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - Reset mid-frame aborts the frame with no pulse.
- rx passes through a 2-FF synchronizer; the FSM sees only the synchronized value rxs.
- FSM states:
  - IDLE: rxs==0 -> START, cnt=0.
  - START: at cnt==HALF_BIT-1, rxs==0 -> DATA (cnt=0, bit_idx=0); rxs==1 -> IDLE (glitch rejected, no pulse).
  - DATA: at cnt==CLKS_PER_BIT-1, shift rxs into MSB of shift register (LSB first on the wire), cnt=0, bit_idx++. After bit_idx 7 -> STOP (or PARITY, see Optional Feature).
  - STOP: at cnt==CLKS_PER_BIT-1, sample rxs, then -> IDLE.
    - rxs==1: byte complete.
    - rxs==0: frame_err pulse, byte discarded.
- Return to IDLE happens mid stop bit, so back-to-back frames with a single stop bit are received without loss.
- cnt width is $clog2(CLKS_PER_BIT). cnt increments every cycle in START/DATA/STOP and never wraps past CLKS_PER_BIT-1.
- Handshake:
  - rx_valid clears in the cycle after rx_valid & rx_ready.
  - rx_data is stable while rx_valid=1.
- Byte complete, by holding-register state:
  - rx_valid=0: load rx_data, rx_valid=1 next cycle.
  - rx_valid=1 & rx_ready=1 in the same cycle: old byte is consumed, new byte loaded, rx_valid stays 1, no overrun.
  - rx_valid=1 & rx_ready=0: new byte dropped, old byte retained, overrun pulses for one cycle.
- Latency: rx_valid rises exactly 1 cycle after the stop-bit sample cycle.
- busy=0 only in IDLE.

Optional Feature:
- Macro: CHARMATRIX_UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP and samples one bit at cnt==CLKS_PER_BIT-1.
  - Even parity is required: XOR of 8 data bits and the parity bit equals 0.
  - Extra output parity_err (1 bit, one-cycle pulse, reset 0) fires at stop-bit time on mismatch; the byte is discarded.
  - If the stop bit is also bad, frame_err takes precedence and parity_err stays 0.
- Undefined:
  - No PARITY state and no parity_err port.
  - Frame is 10 bits (8N1).

Decomposition:
- Package charmatrix_pkg holds:
  - state typedef uart_rx_state_t {IDLE, START, DATA, PARITY, STOP};
  - localparam DATA_BITS=8;
  - default CLKS_PER_BIT constant, shared with the top level.
- One sub-module: charmatrix_sync2, a generic 2-FF synchronizer with a reset-value parameter, reused for other async inputs.

Test Plan (CLKS_PER_BIT=8, HALF_BIT=4):
- Idle line, reset released -> all outputs 0, busy=0 for 100 cycles.
- Send 0x41 (8N1) with rx_ready=1:
  - rx_valid=1 for exactly 1 cycle with rx_data=0x41, 2+4+72+1 = 79 cycles after the rx falling edge.
  - frame_err=0, overrun=0.
- Send 0x55, 0xAA, 0x00, 0xFF back-to-back with rx_ready=0 -> after the first byte rx_data=0x55 stays held and overrun pulses 3 times. Then raise rx_ready -> one transfer of 0x55, rx_valid=0.
- 2-cycle low glitch on idle line -> START aborted, back to IDLE, no rx_valid and no frame_err. Then send 0x3C -> 0x3C received correctly.
- Send 0x7E with stop bit forced low -> frame_err single pulse, rx_valid stays 0, next frame 0x12 received OK.
- Assert rst_n=0 mid data bit 4 of 0xC3 -> outputs 0 immediately. Release and send 0x81 -> rx_data=0x81, no stale bits.
- With CHARMATRIX_UART_RX_PARITY_EN:
  - 0x03 with parity 0 -> accepted.
  - 0x03 with parity 1 -> parity_err pulse, no rx_valid.
